data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words stored (power of two, at least 4).
REQ-002 Parameter AW, default $clog2(DEPTH), word-index width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all writes.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 address  input  32  byte address of the access.
REQ-007 write_data  input  32  store data, right-aligned.
REQ-008 write_enable  input  1  store request.
REQ-009 read_enable  input  1  load request.
REQ-010 funct3  input  3  access size/sign code per RV32I load/store encoding.
REQ-011 read_data  output  32  load result, combinational.
REQ-012 fault  output  1  combinational flag for a misaligned or illegal access.

Function
REQ-013 Storage SHALL be DEPTH words; word index = address[AW+1:2]; address bits above AW+1 are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-014 Byte order SHALL be little-endian: byte lane k = word bits [8k+7:8k], k = address[1:0].
REQ-015 Loads: 000 LB sign-extends the byte, 001 LH sign-extends the half, 010 LW returns the word, 100 LBU zero-extends the byte, 101 LHU zero-extends the half.
REQ-016 Stores: 000 SB writes write_data[7:0] to lane k; 001 SH writes write_data[15:0] to lanes k,k+1; 010 SW writes all lanes; unselected lanes are unchanged.
REQ-017 Reads SHALL be combinational: read_data reflects current contents in the same cycle, with no clock latency.
REQ-018 Writes SHALL commit on the rising clk edge when write_enable=1, rst_n=1 and fault=0.
REQ-019 read_data SHALL be 0 when read_enable=0 or fault=1.
REQ-020 Misalignment: a half access with address[0]=1, or a word access with address[1:0]!=00, is misaligned.
REQ-021 Illegal funct3: loads with 011/110/111 and stores with any code other than 000/001/010.
REQ-022 fault SHALL be 1 when (read_enable or write_enable) is 1 and the access is misaligned or illegal; otherwise 0.
REQ-023 A faulting store SHALL leave memory unchanged.
REQ-024 When read_enable and write_enable are both 1, read_data SHALL show the pre-edge contents and the write commits at the edge. Fault evaluation then uses the store decode (REQ-021) if either decode is illegal.
REQ-025 With both enables 0, memory SHALL hold and fault=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear every memory word to 0x00000000, without waiting for a clock edge.
REQ-027 While rst_n=0, writes are blocked, read_data=0 and fault=0.
REQ-028 If reset asserts mid-cycle with write_enable=1, the write SHALL be discarded. After deassertion, the first rising edge with a valid store commits normally.

Verification
REQ-029 Reset, then SW address 0, data 123 (0x0000007B), one edge, then LW address 0 with read_enable=1 -> read_data=123, fault=0.
REQ-030 SW address 0x10, data 0x80FF7F01, then LB 0x11 -> 0x0000007F, LB 0x12 -> 0xFFFFFFFF, LBU 0x13 -> 0x00000080, LH 0x12 -> 0xFFFF80FF, LHU 0x12 -> 0x000080FF.
REQ-031 SW 0x20 data 0x11223344, then SB 0x21 data 0xAA, then SH 0x22 data 0xBEEF -> LW 0x20 = 0xBEEFAA44.
REQ-032 SW 0x05 data 0xDEADBEEF -> fault=1 during the store, memory unchanged (LW 0x04 = 0). LH 0x03 -> fault=1, read_data=0.
REQ-033 With DEPTH=256: SW address 0x400 data 0x5 -> LW 0x0 = 0x5 (wrap-around).
REQ-034 Write several words, pulse rst_n low between edges -> all words read 0 immediately, and a store issued during reset is not committed.

Source files
------------

// File: rtl/data_memory_if.sv
// Load/store bus between a core's memory stage and the data memory.
// The master drives the access request; the slave returns the load result and fault flag.
interface data_memory_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic        fault;

  modport master (
    output address,
    output write_data,
    output write_enable,
    output read_enable,
    output funct3,
    input  read_data,
    input  fault
  );

  modport slave (
    input  address,
    input  write_data,
    input  write_enable,
    input  read_enable,
    input  funct3,
    output read_data,
    output fault
  );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable little-endian RV32I data memory: combinational loads, clocked stores,
// misalignment/illegal-size fault detection, and an asynchronous clear of every word.
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst_n,
  data_memory_if.slave bus
);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] index;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic          unused_addr_hi;

  assign index          = bus.address[AW+1:2];
  assign lane           = bus.address[1:0];
  assign word           = mem[index];
  // Bits above the word index are ignored, so the address space wraps.
  assign unused_addr_hi = ^bus.address[31:AW+2];

  function automatic logic [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] sb;
    sb = signed'(b);
    return 32'(sb);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] sh;
    sh = signed'(h);
    return 32'(sh);
  endfunction

  logic is_byte;
  logic is_half;
  logic is_word;
  logic misaligned;
  logic load_illegal;
  logic store_illegal;
  logic fault_raw;

  always_comb begin
    is_byte       = (bus.funct3[1:0] == 2'b00);
    is_half       = (bus.funct3[1:0] == 2'b01);
    is_word       = (bus.funct3[1:0] == 2'b10);
    misaligned    = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    load_illegal  = (bus.funct3 == 3'b011) | (bus.funct3 == 3'b110) | (bus.funct3 == 3'b111);
    store_illegal = bus.funct3[2] | (bus.funct3[1:0] == 2'b11);
    // With both enables set, the store decode dominates since its illegal set is the larger.
    fault_raw     = (bus.read_enable | bus.write_enable) &
                    (misaligned | (bus.write_enable & store_illegal) |
                     (bus.read_enable & load_illegal));
  end

  assign bus.fault = rst_n & fault_raw;

  logic [31:0] shifted;
  logic [31:0] load_value;

  always_comb begin
    shifted    = word >> {lane, 3'b000};
    load_value = '0;
    case (bus.funct3)
      3'b000:  load_value = sext8(shifted[7:0]);
      3'b001:  load_value = sext16(shifted[15:0]);
      3'b010:  load_value = word;
      3'b100:  load_value = {24'h0, shifted[7:0]};
      3'b101:  load_value = {16'h0, shifted[15:0]};
      default: load_value = '0;
    endcase
  end

  assign bus.read_data = (rst_n & bus.read_enable & ~fault_raw) ? load_value : 32'h0;

  logic [3:0]  byte_en;
  logic [31:0] store_lanes;
  logic        commit;

  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = bus.write_data;
    if (is_byte) begin
      byte_en     = 4'b0001 << lane;
      store_lanes = {4{bus.write_data[7:0]}};
    end else if (is_half) begin
      byte_en     = 4'b0011 << lane;
      store_lanes = {2{bus.write_data[15:0]}};
    end else if (is_word) begin
      byte_en     = 4'b1111;
    end
    commit = bus.write_enable & ~fault_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[index][8*k +: 8] <= store_lanes[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, reset sequences, and
// randomized accesses checked against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;

  logic clk;
  logic rst_n;
  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [BYTES];

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_fault;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic model_fault(input logic we, input logic re,
                                       input logic [31:0] a, input logic [2:0] f3);
    int  sz;
    int  lo;
    logic mis, ld_ill, st_ill;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 1;
    endcase
    lo     = int'(a[1:0]);
    mis    = (lo % sz) != 0;
    ld_ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    st_ill = (f3 > 3'd2);
    return (we || re) && (mis || (we && st_ill) || (re && ld_ill));
  endfunction

  function automatic logic [31:0] model_load(input logic we, input logic re,
                                             input logic [31:0] a, input logic [2:0] f3);
    int base;
    logic [7:0] b0, b1, b2, b3;
    if (!re || model_fault(we, re, a, f3)) return 32'h0;
    base = int'(a[9:0]);
    b0 = ref_mem[base];
    b1 = ref_mem[(base + 1) % BYTES];
    b2 = ref_mem[(base + 2) % BYTES];
    b3 = ref_mem[(base + 3) % BYTES];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd2:    return {b3, b2, b1, b0};
      3'd4:    return {24'h0, b0};
      3'd5:    return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic we, input logic re,
                             input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int base;
    int n;
    if (!we || model_fault(we, re, a, f3)) return;
    base = int'(a[9:0]);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[(base + k) % BYTES] = d[8*k +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.address      = a;
    bus.write_data   = d;
    bus.funct3       = f3;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.we, v.re, v.addr, v.wdata, v.f3);
    #1;
    check32({v.name, ".read_data"}, bus.read_data, v.exp_rd);
    check1({v.name, ".fault"}, bus.fault, v.exp_fault);
    @(posedge clk);
    #1;
    model_store(v.we, v.re, v.addr, v.wdata, v.f3);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    model_clear();
    drive(1'b1, 1'b1, 32'h3, 32'hFFFF_FFFF, 3'd2);
    #2;
    check32("reset.read_data", bus.read_data, 32'h0);
    check1("reset.fault", bus.fault, 1'b0);
    #5 rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);

    //             we    re    addr          wdata          f3    exp_rd         flt
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0000_007B, 3'd2, 32'h0000_0000, 1'b0, "sw_0"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0,         3'd2, 32'h0000_007B, 1'b0, "lw_0"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h80FF_7F01, 3'd2, 32'h0000_0000, 1'b0, "sw_10"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0011, 32'h0,         3'd0, 32'h0000_007F, 1'b0, "lb_11"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         3'd0, 32'hFFFF_FFFF, 1'b0, "lb_12"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0013, 32'h0,         3'd4, 32'h0000_0080, 1'b0, "lbu_13"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         3'd1, 32'hFFFF_80FF, 1'b0, "lh_12"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0,         3'd5, 32'h0000_80FF, 1'b0, "lhu_12"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344, 3'd2, 32'h0000_0000, 1'b0, "sw_20"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0021, 32'h0000_00AA, 3'd0, 32'h0000_0000, 1'b0, "sb_21"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 3'd1, 32'h0000_0000, 1'b0, "sh_22"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'h0,         3'd2, 32'hBEEF_AA44, 1'b0, "lw_20"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF, 3'd2, 32'h0000_0000, 1'b1, "sw_5_mis"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0004, 32'h0,         3'd2, 32'h0000_0000, 1'b0, "lw_4"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0003, 32'h0,         3'd1, 32'h0000_0000, 1'b1, "lh_3_mis"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0005, 3'd2, 32'h0000_0000, 1'b0, "sw_400"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0,         3'd2, 32'h0000_0005, 1'b0, "lw_wrap"});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 3'd2, 32'hBEEF_AA44, 1'b0, "rw_20"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'h0,         3'd2, 32'h1234_5678, 1'b0, "lw_20_new"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0,         3'd3, 32'h0000_0000, 1'b1, "ld_ill"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 3'd4, 32'h0000_0000, 1'b1, "st_ill"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0,         3'd2, 32'h0000_0005, 1'b0, "lw_0_kept"});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 3'd4, 32'h0000_0000, 1'b1, "rw_ill"});
    tbl.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0,         3'd2, 32'h80FF_7F01, 1'b0, "lw_10_kept"});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0001, 32'h0,         3'd3, 32'h0000_0000, 1'b0, "idle"});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000, 3'd1, 32'h0000_0000, 1'b0, "sh_2_ok"});

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous clear: no clock edge between asserting and releasing reset.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h20, 32'h0, 3'd2);
    #1 check32("pre_rst.lw_20", bus.read_data, 32'h1234_5678);
    rst_n = 1'b0;
    #1 check32("in_rst.read_data", bus.read_data, 32'h0);
    bus.address = 32'h21;
    #1 check1("in_rst.fault", bus.fault, 1'b0);
    bus.address = 32'h20;
    rst_n = 1'b1;
    #1 check32("post_rst.lw_20", bus.read_data, 32'h0);
    bus.address = 32'h10;
    #1 check32("post_rst.lw_10", bus.read_data, 32'h0);
    model_clear();

    // A store held across an edge while in reset is discarded.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h30, 32'hCAFE_BABE, 3'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'h30, 32'h0, 3'd2);
    #1 check32("rst_store_dropped", bus.read_data, 32'h0);
    run_vec('{1'b1, 1'b0, 32'h30, 32'hCAFE_BABE, 3'd2, 32'h0, 1'b0, "sw_30_after_rst"});
    run_vec('{1'b0, 1'b1, 32'h30, 32'h0, 3'd2, 32'hCAFE_BABE, 1'b0, "lw_30_after_rst"});

    for (int n = 0; n < 400; n++) begin
      v.we        = 1'($urandom_range(0, 1));
      v.re        = 1'($urandom_range(0, 1));
      v.addr      = $urandom & 32'hFFFF_F03F;
      v.wdata     = $urandom;
      v.f3        = 3'($urandom_range(0, 7));
      v.exp_rd    = model_load(v.we, v.re, v.addr, v.f3);
      v.exp_fault = model_fault(v.we, v.re, v.addr, v.f3);
      v.name      = $sformatf("rnd%0d", n);
      run_vec(v);
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
